// File: rtl/bcd_pkg.sv
// bcd_pkg: shared state encoding and digit width for the iterative binary-to-BCD converter
package bcd_pkg;
    localparam int BCD_DIGIT_W = 4;
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
endpackage

// File: rtl/bcd_add3.sv
// bcd_add3: double-dabble digit correction, adds 3 to a BCD digit that is 5 or more
// d: BCD digit before the shift; q: corrected digit
module bcd_add3
    import bcd_pkg::*;
(
    input  logic [BCD_DIGIT_W-1:0] d,
    output logic [BCD_DIGIT_W-1:0] q
);
    assign q = (d >= 4'd5) ? d + 4'd3 : d;
endmodule

// File: rtl/bcd_iter.sv
// bcd_iter: iterative shift-and-add-3 binary to BCD converter with valid/ready handshakes
// clk, rst_n (async, active low); in_valid/in_ready/in_data operand side;
// out_valid/out_ready result side carrying out_bcd (ones digit in [3:0]), out_neg and out_ovf
module bcd_iter
    import bcd_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 3,
    parameter int SIGNED = 1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [WIDTH-1:0]              in_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [BCD_DIGIT_W*DIGITS-1:0] out_bcd,
    output logic                          out_neg,
    output logic                          out_ovf
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam int BW = BCD_DIGIT_W * DIGITS;
    state_t          state;
    logic [WIDTH-1:0] mag;
    logic [BW-1:0]   dig;
    logic [BW-1:0]   adj;
    logic [CW-1:0]   cnt;
    logic            ovf;
    logic            neg;
    logic            in_neg;
    genvar i;
    for (i = 0; i < DIGITS; i++) begin : g_dig
        bcd_add3 u_add3 (
            .d(dig[i*BCD_DIGIT_W +: BCD_DIGIT_W]),
            .q(adj[i*BCD_DIGIT_W +: BCD_DIGIT_W])
        );
    end
    assign in_neg    = (SIGNED != 0) && in_data[WIDTH-1];
    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    // The counter runs WIDTH..1 for the shifts; the cycle at zero publishes the result,
    // giving out_valid WIDTH+1 edges after acceptance.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            mag     <= '0;
            dig     <= '0;
            cnt     <= '0;
            ovf     <= 1'b0;
            neg     <= 1'b0;
            out_bcd <= '0;
            out_neg <= 1'b0;
            out_ovf <= 1'b0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    mag   <= in_neg ? WIDTH'(-in_data) : in_data;
                    neg   <= in_neg;
                    dig   <= '0;
                    ovf   <= 1'b0;
                    cnt   <= CW'(WIDTH);
                    state <= SHIFT;
                end
                SHIFT: if (cnt != '0) begin
                    // the bit leaving the top digit is worth 10^DIGITS, so dropping it keeps the result mod 10^DIGITS
                    dig <= {adj[BW-2:0], mag[WIDTH-1]};
                    mag <= {mag[WIDTH-2:0], 1'b0};
                    ovf <= ovf | adj[BW-1];
                    cnt <= cnt - 1'b1;
                end else begin
                    out_bcd <= dig;
                    out_neg <= neg;
                    out_ovf <= ovf;
                    state   <= DONE;
                end
                DONE: if (out_ready) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule
